id_inst_queue: RTL and testbench



---
 rtl/id_inst_queue.sv | 128 ++++++++++++
 tb/tb_id_inst_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO carrying fetch context per entry.
// Delay-slot flag is captured at enqueue time and survives IF stalls.
module id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_in,
  output logic                       id_allowin_out,
  input  logic [31:0]                if_PC_in,
  input  logic [31:0]                if_NPC_in,
  input  logic [31:0]                if_NNPC_in,
  input  logic [31:0]                if_Instruct_in,
  input  logic                       if_bj_in,
  input  logic                       if_exception_in,
  input  logic [4:0]                 if_ExcCode_in,
  input  logic [31:0]                if_error_VAddr_in,
  input  logic                       id_ready_in,
  output logic                       id_valid_out,
  output logic [31:0]                id_PC_out,
  output logic [31:0]                id_NPC_out,
  output logic [31:0]                id_NNPC_out,
  output logic [31:0]                id_Instruct_out,
  output logic [31:0]                id_error_VAddr_out,
  output logic                       id_exception_out,
  output logic [4:0]                 id_ExcCode_out,
  output logic                       id_bd_out,
  input  logic                       wb_ClrStpJmp_in,
  output logic                       if_afull_out,
  output logic [$clog2(DEPTH+1)-1:0] id_count_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] nnpc;
    logic [31:0] instruct;
    logic [31:0] vaddr;
    logic        exception;
    logic [4:0]  exc_code;
    logic        bd;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            bj_last_q, bj_last_d;
  logic            enq, deq;
  entry_t          head;

  assign id_allowin_out = (count_q != CW'(DEPTH));
  assign id_valid_out   = (count_q != '0);
  assign enq = if_valid_in & id_allowin_out & ~wb_ClrStpJmp_in;
  assign deq = id_valid_out & id_ready_in & ~wb_ClrStpJmp_in;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    bj_last_d = bj_last_q;
    if (wb_ClrStpJmp_in) begin
      // Flush wins; storage is left stale since the head is marked invalid.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      bj_last_d = 1'b0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q].pc        = if_PC_in;
        mem_d[wr_ptr_q].npc       = if_NPC_in;
        mem_d[wr_ptr_q].nnpc      = if_NNPC_in;
        mem_d[wr_ptr_q].instruct  = if_Instruct_in;
        mem_d[wr_ptr_q].vaddr     = if_error_VAddr_in;
        mem_d[wr_ptr_q].exception = if_exception_in;
        mem_d[wr_ptr_q].exc_code  = if_ExcCode_in;
        mem_d[wr_ptr_q].bd        = bj_last_q;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        bj_last_d = if_bj_in;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bj_last_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bj_last_q <= bj_last_d;
    end
  end

  assign head               = mem_q[rd_ptr_q];
  assign id_PC_out          = head.pc;
  assign id_NPC_out         = head.npc;
  assign id_NNPC_out        = head.nnpc;
  assign id_Instruct_out    = head.instruct;
  assign id_error_VAddr_out = head.vaddr;
  assign id_exception_out   = head.exception;
  assign id_ExcCode_out     = head.exc_code;
  assign id_bd_out          = head.bd;
  assign if_afull_out       = (count_q >= CW'(AFULL));
  assign id_count_out       = count_q;

endmodule

// File: tb/tb_id_inst_queue.sv
// Randomized and directed bench for id_inst_queue against a queue-based model.
module tb_id_inst_queue;
   localparam int DEPTH = 4;
   localparam int AFULL = DEPTH - 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ifValid = 1'b0, allowIn;
   logic [31:0] ifPc = '0, ifNpc = '0, ifNnpc = '0, ifInst = '0, ifVaddr = '0;
   logic ifBj = 1'b0, ifExc = 1'b0;
   logic [4:0] ifCode = '0;
   logic idReady = 1'b0, idValid;
   logic [31:0] idPc, idNpc, idNnpc, idInst, idVaddr;
   logic idExc, idBd;
   logic [4:0] idCode;
   logic flush = 1'b0;
   logic afull;
   logic [CW-1:0] count;

   typedef struct {
      logic [31:0] pc, npc, nnpc, inst, vaddr;
      logic        exc;
      logic [4:0]  code;
      logic        bd;
   } ModelEntry;

   ModelEntry modelQ[$];
   logic      modelBjLast = 1'b0;
   int        compareCount = 0;
   int        mismatchCount = 0;

   id_inst_queue #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
      .clk(clk), .rst(rst),
      .if_valid_in(ifValid), .id_allowin_out(allowIn),
      .if_PC_in(ifPc), .if_NPC_in(ifNpc), .if_NNPC_in(ifNnpc),
      .if_Instruct_in(ifInst), .if_bj_in(ifBj),
      .if_exception_in(ifExc), .if_ExcCode_in(ifCode),
      .if_error_VAddr_in(ifVaddr),
      .id_ready_in(idReady), .id_valid_out(idValid),
      .id_PC_out(idPc), .id_NPC_out(idNpc), .id_NNPC_out(idNnpc),
      .id_Instruct_out(idInst), .id_error_VAddr_out(idVaddr),
      .id_exception_out(idExc), .id_ExcCode_out(idCode), .id_bd_out(idBd),
      .wb_ClrStpJmp_in(flush), .if_afull_out(afull), .id_count_out(count)
   );

   always #5 clk = ~clk;

   // One comparison: count it, and report it if observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compare every visible DUT output against the reference queue
   task automatic compareModel();
      checkOutput("count", 32'(count), 32'(modelQ.size()));
      checkOutput("valid", 32'(idValid), 32'(modelQ.size() != 0));
      checkOutput("allowin", 32'(allowIn), 32'(modelQ.size() != DEPTH));
      checkOutput("afull", 32'(afull), 32'(modelQ.size() >= AFULL));
      if (modelQ.size() != 0) begin
         checkOutput("head_pc", idPc, modelQ[0].pc);
         checkOutput("head_npc", idNpc, modelQ[0].npc);
         checkOutput("head_nnpc", idNnpc, modelQ[0].nnpc);
         checkOutput("head_inst", idInst, modelQ[0].inst);
         checkOutput("head_vaddr", idVaddr, modelQ[0].vaddr);
         checkOutput("head_exc", 32'(idExc), 32'(modelQ[0].exc));
         checkOutput("head_code", 32'(idCode), 32'(modelQ[0].code));
         checkOutput("head_bd", 32'(idBd), 32'(modelQ[0].bd));
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, check after the rising edge
   task automatic applyStimulus(input logic v, input logic bj, input logic ready, input logic fl,
                                input logic [31:0] pc, input logic exc = 1'b0,
                                input logic [4:0] code = 5'd0, input logic [31:0] vaddr = 32'd0);
      ModelEntry e;
      bit doEnq, doDeq;
      ifValid = v; ifBj = bj; idReady = ready; flush = fl;
      ifPc = pc; ifNpc = pc + 32'd4; ifNnpc = pc + 32'd8;
      ifInst = pc ^ 32'h3C1D_0000; ifExc = exc; ifCode = code; ifVaddr = vaddr;
      if (fl) begin
         modelQ.delete();
         modelBjLast = 1'b0;
      end else begin
         doEnq = v && (modelQ.size() != DEPTH);
         doDeq = ready && (modelQ.size() != 0);
         if (doDeq) void'(modelQ.pop_front());
         if (doEnq) begin
            e.pc = pc; e.npc = pc + 32'd4; e.nnpc = pc + 32'd8;
            e.inst = pc ^ 32'h3C1D_0000; e.exc = exc; e.code = code;
            e.vaddr = vaddr; e.bd = modelBjLast;
            modelQ.push_back(e);
            modelBjLast = bj;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compareModel();
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, 32'(idValid), 32'd0);
      checkOutput({tag, "_allowin"}, 32'(allowIn), 32'd1);
      checkOutput({tag, "_afull"}, 32'(afull), 32'd0);
      checkOutput({tag, "_count"}, 32'(count), 32'd0);
      checkOutput({tag, "_pc"}, idPc, 32'd0);
      checkOutput({tag, "_npc"}, idNpc, 32'd0);
      checkOutput({tag, "_inst"}, idInst, 32'd0);
      checkOutput({tag, "_vaddr"}, idVaddr, 32'd0);
      checkOutput({tag, "_exc"}, {26'd0, idExc, idCode}, 32'd0);
      checkOutput({tag, "_bd"}, 32'(idBd), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      // Fill to full with ID stalled, then drain in order
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC0_0000 + 32'(4 * i));
         if (i == 2) checkOutput("fill_afull_at3", 32'(afull), 32'd1);
      end
      checkOutput("fill_count4", 32'(count), 32'd4);
      checkOutput("fill_allowin0", 32'(allowIn), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000);
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_pc", idPc, 32'hBFC0_0000 + 32'(4 * i));
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      end
      checkOutput("drain_empty", 32'(idValid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      // Back-to-back streaming across the pointer wrap
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000 + 32'(4 * i));
         checkOutput("stream_head", idPc, 32'h0000_2000 + 32'(4 * i));
         checkOutput("stream_cnt_le1", 32'(count <= 1), 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      // Delay slot survives an IF stall
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0108);
      checkOutput("bd_0x100", {idPc[30:0], idBd}, {31'h0000_0100, 1'b0});
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("bd_0x104", {idPc[30:0], idBd}, {31'h0000_0104, 1'b1});
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("bd_0x108", {idPc[30:0], idBd}, {31'h0000_0108, 1'b0});
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      // Flush with simultaneous enqueue and dequeue; last entry was a jump
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3000 + 32'(4 * i));
      checkOutput("flush_pre_count", 32'(count), 32'd3);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_4000);
      checkOutput("flush_count0", 32'(count), 32'd0);
      checkOutput("flush_valid0", 32'(idValid), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC0_0380);
      checkOutput("flush_redirect_pc", idPc, 32'hBFC0_0380);
      checkOutput("flush_redirect_bd", 32'(idBd), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      // Exception fields carried through, then a clean entry
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 1'b1, 5'h04, 32'h0000_0001);
      checkOutput("exc_flag", 32'(idExc), 32'd1);
      checkOutput("exc_code", 32'(idCode), 32'h04);
      checkOutput("exc_vaddr", idVaddr, 32'h0000_0001);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_5004);
      checkOutput("exc_next_clean", 32'(idExc), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 19) == 0), $urandom, 1'($urandom),
                       5'($urandom), $urandom);
      end

      // Asynchronous reset between edges with two entries queued
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_6000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_6004);
      checkOutput("areset_pre_count", 32'(count), 32'd2);
      ifValid = 1'b0; idReady = 1'b0;
      #1 rst = 1'b1;
      #1 checkResetOutputs("areset");
      #1 rst = 1'b0;
      modelQ.delete();
      modelBjLast = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7000);
      checkOutput("areset_bd_cleared", 32'(idBd), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end
endmodule
